// File: rtl/jedro_1_pkg.sv
// Shared types and constants for the jedro_1 instruction fetch path.
package jedro_1_pkg;

  // Prefetch sequencer states: a single idle cycle after reset, then fetching.
  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } prefetch_state_e;

  // Canonical RISC-V NOP (addi x0, x0, 0), used by the decoder for bubbles.
  localparam logic [31:0] NOP = 32'h0000_0013;

  // One buffered fetch: the instruction word together with its address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;

endpackage

// File: rtl/jedro_1_fifo.sv
// Small synchronous FIFO with a clear that overrides push and pop.
module jedro_1_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == DEPTH_V);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop needs data; a push needs room, which a simultaneous pop provides.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage array; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; clear empties the FIFO outright.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/jedro_1_prefetch.sv
// Instruction prefetcher: issues sequential ROM reads, absorbs the one-cycle
// read latency and buffers {pc, instr} pairs for the decoder.
module jedro_1_prefetch
  import jedro_1_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  output logic                  imem_en_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  jmp_i,
  input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  prefetch_state_e       state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic                  inflight_q, inflight_d;
  logic [EW-1:0]         last_q, last_d;

  logic [EW-1:0]         head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           pending;
  logic                  req;
  logic                  push;
  logic                  pop;
  logic                  unused_jmp_lsb;

  assign unused_jmp_lsb = ^jmp_addr_i[1:0];

  // The ROM port depends only on registered state, so jmp_i and
  // instr_ready_i never reach imem_en_o combinationally. A read that
  // coincides with a jump is simply never marked in flight, so its data
  // is ignored on the following cycle.
  assign imem_en_o   = req;
  assign imem_addr_o = req ? pc_q : '0;

  assign push          = inflight_q & ~fifo_full;
  assign pop           = instr_valid_o & instr_ready_i & ~jmp_i;
  assign instr_valid_o = ~fifo_empty;
  assign {pc_o, instr_o} = fifo_empty ? last_q : head;

  // Next-state logic: credit-based request issue, PC advance and redirect.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = 1'b0;
    last_d     = last_q;
    req        = 1'b0;
    pending    = {1'b0, fifo_count} + (CW+1)'(inflight_q);

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     req = (pending < DEPTH_V);
      default: state_d = BOOT;
    endcase

    if (req && !jmp_i) begin
      inflight_d = 1'b1;
      rsp_pc_d   = pc_q;
      pc_d       = pc_q + ADDR_WIDTH'(4);
    end

    if (jmp_i) begin
      pc_d = {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
    end

    if (!fifo_empty) begin
      last_d = head;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q    <= BOOT;
      pc_q       <= {BOOT_ADDR[ADDR_WIDTH-1:2], 2'b00};
      rsp_pc_q   <= '0;
      inflight_q <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      last_q     <= last_d;
    end
  end

  jedro_1_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (jmp_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({rsp_pc_q, imem_rdata_i}),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_jedro_1_prefetch.sv
// Directed testbench for jedro_1_prefetch with a one-cycle-latency ROM model
// whose word at byte address a is 0x1000 + a/4.
module tb_jedro_1_prefetch;

  logic        clk;
  logic        rstn;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        jmp;
  logic [31:0] jmp_addr;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  jedro_1_prefetch dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .imem_en_o     (imem_en),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .jmp_i         (jmp),
    .jmp_addr_i    (jmp_addr),
    .instr_o       (instr),
    .pc_o          (pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: data for an enabled read appears one cycle later; idle
  // cycles return a marker value so stray captures are visible.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h1000 + (imem_addr >> 2);
    else         imem_rdata <= 32'hDEAD_BEEF;
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset; returns in the BOOT cycle with reset released.
  task automatic do_reset(input logic rdy);
    rstn        = 1'b0;
    jmp         = 1'b0;
    jmp_addr    = '0;
    instr_ready = rdy;
    tick();
    rstn = 1'b1;
  endtask

  // Reset values on every output.
  task automatic test_reset();
    rstn = 1'b0; jmp = 1'b0; jmp_addr = '0; instr_ready = 1'b0;
    tick(); tick();
    checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b want 0", imem_en); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h want 0", pc); end
    checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h want 0", instr); end
  endtask

  // Boot sequence and sustained one-per-cycle streaming.
  task automatic test_stream();
    do_reset(1'b1);
    checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL boot_no_req: got %b want 0", imem_en); end
    tick();
    checks++; if ({imem_en, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("[TB] FAIL first_req: got %b/%h want 1/0", imem_en, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_latency: got %b want 0", instr_valid); end
    checks++; if ({imem_en, imem_addr} !== {1'b1, 32'h4}) begin errors++; $display("[TB] FAIL second_req: got %b/%h want 1/4", imem_en, imem_addr); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if ({instr_valid, pc, instr} !== {1'b1, 32'(4*i), 32'h1000 + 32'(i)}) begin
        errors++; $display("[TB] FAIL stream_out[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", i, instr_valid, pc, instr, 32'(4*i), 32'h1000 + 32'(i));
      end
      checks++;
      if ({imem_en, imem_addr} !== {1'b1, 32'(4*(i+2))}) begin
        errors++; $display("[TB] FAIL stream_req[%0d]: got %b/%h want 1/%h", i, imem_en, imem_addr, 32'(4*(i+2)));
      end
    end
  endtask

  // Back-pressure: exactly FIFO_DEPTH requests, then drain and resume.
  task automatic test_full();
    logic [31:0] seen [$];
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      if (imem_en) seen.push_back(imem_addr);
      tick();
    end
    checks++; if (seen.size() != 4) begin errors++; $display("[TB] FAIL full_req_count: got %0d want 4", seen.size()); end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checks++; if (seen[i] !== 32'(4*i)) begin errors++; $display("[TB] FAIL full_req_addr[%0d]: got %h want %h", i, seen[i], 32'(4*i)); end
    end
    checks++; if (imem_en !== 1'b0) begin errors++; $display("[TB] FAIL full_no_req: got %b want 0", imem_en); end
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({instr_valid, pc, instr} !== {1'b1, 32'(4*k), 32'h1000 + 32'(k)}) begin
        errors++; $display("[TB] FAIL drain[%0d]: got v=%b pc=%h instr=%h want v=1 pc=%h", k, instr_valid, pc, instr, 32'(4*k));
      end
      if (k == 1) begin
        checks++; if ({imem_en, imem_addr} !== {1'b1, 32'h10}) begin errors++; $display("[TB] FAIL resume_req: got %b/%h want 1/10", imem_en, imem_addr); end
      end
      tick();
    end
  endtask

  // Jump while the 0x10 read is in flight.
  task automatic test_jump();
    do_reset(1'b1);
    for (int i = 0; i < 6; i++) tick();
    jmp = 1'b1; jmp_addr = 32'h203;
    tick();
    jmp = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL jump_flush: got %b want 0", instr_valid); end
    checks++; if ({pc, instr} !== {32'hC, 32'h1003}) begin errors++; $display("[TB] FAIL jump_hold: got %h/%h want c/1003", pc, instr); end
    checks++; if ({imem_en, imem_addr} !== {1'b1, 32'h200}) begin errors++; $display("[TB] FAIL jump_target_req: got %b/%h want 1/200", imem_en, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL jump_bubble2: got %b want 0", instr_valid); end
    checks++; if (imem_addr !== 32'h204) begin errors++; $display("[TB] FAIL jump_next_req: got %h want 204", imem_addr); end
    tick();
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h200, 32'h1080}) begin errors++; $display("[TB] FAIL jump_target_out: got v=%b pc=%h instr=%h want 1/200/1080", instr_valid, pc, instr); end
    tick();
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h204, 32'h1081}) begin errors++; $display("[TB] FAIL jump_follow_out: got v=%b pc=%h instr=%h want 1/204/1081", instr_valid, pc, instr); end
  endtask

  // Jump coincident with a pop from a full FIFO.
  task automatic test_jump_pop();
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) tick();
    checks++; if ({instr_valid, pc} !== {1'b1, 32'h0}) begin errors++; $display("[TB] FAIL jpop_pre: got v=%b pc=%h want 1/0", instr_valid, pc); end
    instr_ready = 1'b1; jmp = 1'b1; jmp_addr = 32'h100;
    tick();
    jmp = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL jpop_empty: got %b want 0", instr_valid); end
    checks++; if ({imem_en, imem_addr} !== {1'b1, 32'h100}) begin errors++; $display("[TB] FAIL jpop_req: got %b/%h want 1/100", imem_en, imem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL jpop_bubble2: got %b want 0", instr_valid); end
    tick();
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h100, 32'h1040}) begin errors++; $display("[TB] FAIL jpop_out0: got v=%b pc=%h instr=%h want 1/100/1040", instr_valid, pc, instr); end
    tick();
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h104, 32'h1041}) begin errors++; $display("[TB] FAIL jpop_out1: got v=%b pc=%h instr=%h want 1/104/1041", instr_valid, pc, instr); end
  endtask

  // Two consecutive jumps: the second target wins.
  task automatic test_back_to_back();
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) tick();
    jmp = 1'b1; jmp_addr = 32'h300;
    tick();
    jmp_addr = 32'h400;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flush1: got %b want 0", instr_valid); end
    tick();
    jmp = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flush2: got %b want 0", instr_valid); end
    checks++; if ({imem_en, imem_addr} !== {1'b1, 32'h400}) begin errors++; $display("[TB] FAIL b2b_req: got %b/%h want 1/400", imem_en, imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h404) begin errors++; $display("[TB] FAIL b2b_next_req: got %h want 404", imem_addr); end
    tick();
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h400, 32'h1100}) begin errors++; $display("[TB] FAIL b2b_out: got v=%b pc=%h instr=%h want 1/400/1100", instr_valid, pc, instr); end
    tick();
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h404, 32'h1101}) begin errors++; $display("[TB] FAIL b2b_out1: got v=%b pc=%h instr=%h want 1/404/1101", instr_valid, pc, instr); end
  endtask

  // Fetch PC wraps from the top of the address space; low jump bits ignored.
  task automatic test_wrap();
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) tick();
    jmp = 1'b1; jmp_addr = 32'hFFFF_FFFE;
    tick();
    jmp = 1'b0;
    checks++; if ({imem_en, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin errors++; $display("[TB] FAIL wrap_top_req: got %b/%h want 1/fffffffc", imem_en, imem_addr); end
    tick();
    checks++; if ({imem_en, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("[TB] FAIL wrap_req: got %b/%h want 1/0", imem_en, imem_addr); end
    tick();
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'hFFFF_FFFC, 32'h4000_0FFF}) begin errors++; $display("[TB] FAIL wrap_out0: got v=%b pc=%h instr=%h want 1/fffffffc/40000fff", instr_valid, pc, instr); end
    tick();
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h0, 32'h1000}) begin errors++; $display("[TB] FAIL wrap_out1: got v=%b pc=%h instr=%h want 1/0/1000", instr_valid, pc, instr); end
  endtask

  // Reset with a full FIFO, then the boot sequence repeats.
  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pre: got %b want 1", instr_valid); end
    rstn = 1'b0;
    tick();
    checks++; if ({imem_en, instr_valid} !== 2'b00) begin errors++; $display("[TB] FAIL rmid_idle: got en=%b v=%b want 0/0", imem_en, instr_valid); end
    checks++; if ({pc, instr} !== 64'h0) begin errors++; $display("[TB] FAIL rmid_out: got %h/%h want 0/0", pc, instr); end
    rstn = 1'b1; instr_ready = 1'b1;
    tick();
    checks++; if ({imem_en, imem_addr} !== {1'b1, 32'h0}) begin errors++; $display("[TB] FAIL rmid_boot_req: got %b/%h want 1/0", imem_en, imem_addr); end
    tick(); tick();
    checks++; if ({instr_valid, pc, instr} !== {1'b1, 32'h0, 32'h1000}) begin errors++; $display("[TB] FAIL rmid_boot_out: got v=%b pc=%h instr=%h want 1/0/1000", instr_valid, pc, instr); end
  endtask

  // Scenario sequence and summary.
  initial begin
    rstn = 1'b0; jmp = 1'b0; jmp_addr = '0; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_jump();
    test_jump_pop();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
